// File: rtl/sysid_verifier.sv
//------------------------------------------------------------------------------
// sysid_verifier: reads the sysid ID and timestamp words and compares them to
// expected constants. Optional retry passes on mismatch: SYSID_VERIFIER_RETRY_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sysid_verifier #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h534D_4BA5,
  parameter int          READ_LATENCY = 1,
  parameter int          RETRY_MAX    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  attempts
);

  if (READ_LATENCY < 0 || READ_LATENCY > 7 || RETRY_MAX < 0 || RETRY_MAX > 15) begin : g_param_check
    $error("sysid_verifier: READ_LATENCY or RETRY_MAX out of range");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic [3:0]  attempts_q, attempts_d;
  logic        done_q, done_d;

  logic id_match;
  logic ts_match;

  assign id_match = (id_value_q == EXPECTED_ID);
  assign ts_match = (ts_value_q == EXPECTED_TS);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    attempts_d = attempts_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RD_ID;
          cnt_d      = 3'd0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          attempts_d = 4'd1;
        end
      end
      RD_ID: begin
        if (cnt_q == LAST_CNT) begin
          id_value_d = sysid_readdata;
          state_d    = RD_TS;
          cnt_d      = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RD_TS: begin
        if (cnt_q == LAST_CNT) begin
          ts_value_d = sysid_readdata;
          state_d    = CHECK;
          cnt_d      = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      CHECK: begin
        id_ok_d = id_match;
        ts_ok_d = ts_match;
        state_d = DONE;
`ifdef SYSID_VERIFIER_RETRY_EN
        // attempts is 4 bits, so a pass count of 15 must stop even if RETRY_MAX allows more
        if (!(id_match && ts_match) && (attempts_q <= 4'(RETRY_MAX)) && (attempts_q != 4'hF)) begin
          state_d    = RD_ID;
          cnt_d      = 3'd0;
          attempts_d = attempts_q + 4'd1;
        end
`endif
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      attempts_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      attempts_q <= attempts_d;
      done_q     <= done_d;
    end
  end

  assign sysid_read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign sysid_address = (state_q == RD_TS);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign id_ok         = id_ok_q;
  assign ts_ok         = ts_ok_q;
  assign id_value      = id_value_q;
  assign ts_value      = ts_value_q;
  assign attempts      = attempts_q;

endmodule

`default_nettype wire

// File: tb/tb_sysid_verifier.sv
// Bench for sysid_verifier: three instances (READ_LATENCY 1, 0, 7) against a latency-aware sysid slave model.
`default_nettype none

module tb_sysid_verifier;

  localparam logic [31:0] EXP_ID  = 32'h0000_0000;
  localparam logic [31:0] EXP_TS  = 32'h534D_4BA5;
  localparam int          RETRIES = 3;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic [31:0] id_v;
    logic [31:0] ts_v;
    logic [3:0]  att;
    int          lat;
  } exp_t;

  exp_t sb[$];

  logic clock = 1'b0;
  logic reset;
  logic start;
  always #5 clock = ~clock;

  logic        busy [3];
  logic        done [3];
  logic        rd   [3];
  logic        addr [3];
  logic        idok [3];
  logic        tsok [3];
  logic [31:0] rdata[3];
  logic [31:0] idv  [3];
  logic [31:0] tsv  [3];
  logic [3:0]  att  [3];

  logic [31:0] id_word[3];
  logic [31:0] ts_word[3];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int acc[3];
  int done_cnt0  = 0;

  sysid_verifier #(.READ_LATENCY(1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start),
    .sysid_address(addr[0]), .sysid_read(rd[0]), .sysid_readdata(rdata[0]),
    .busy(busy[0]), .done(done[0]), .id_ok(idok[0]), .ts_ok(tsok[0]),
    .id_value(idv[0]), .ts_value(tsv[0]), .attempts(att[0]));

  sysid_verifier #(.READ_LATENCY(0)) u_dut1 (
    .clock(clock), .reset(reset), .start(start),
    .sysid_address(addr[1]), .sysid_read(rd[1]), .sysid_readdata(rdata[1]),
    .busy(busy[1]), .done(done[1]), .id_ok(idok[1]), .ts_ok(tsok[1]),
    .id_value(idv[1]), .ts_value(tsv[1]), .attempts(att[1]));

  sysid_verifier #(.READ_LATENCY(7)) u_dut2 (
    .clock(clock), .reset(reset), .start(start),
    .sysid_address(addr[2]), .sysid_read(rd[2]), .sysid_readdata(rdata[2]),
    .busy(busy[2]), .done(done[2]), .id_ok(idok[2]), .ts_ok(tsok[2]),
    .id_value(idv[2]), .ts_value(tsv[2]), .attempts(att[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Slave model: readdata is only valid once the same address has been held for READ_LATENCY cycles.
  logic s_last_rd  [3];
  logic s_last_addr[3];
  int   s_run      [3];

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        s_last_rd[i]   <= 1'b0;
        s_last_addr[i] <= 1'b0;
        s_run[i]       <= 0;
      end else begin
        s_run[i]       <= (rd[i] && s_last_rd[i] && addr[i] == s_last_addr[i]) ? s_run[i] + 1 : (rd[i] ? 1 : 0);
        s_last_rd[i]   <= rd[i];
        s_last_addr[i] <= addr[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      int age;
      age = (rd[i] && s_last_rd[i] && addr[i] == s_last_addr[i]) ? s_run[i] : 0;
      rdata[i] = (rd[i] && age == lat_of(i)) ? (addr[i] ? ts_word[i] : id_word[i]) : 32'hDEAD_BEEF;
    end
  end

  always @(posedge clock) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++)
      if (!reset && start && !busy[i]) acc[i] = cyc;
  end

  logic m_rd  [3];
  logic m_addr[3];
  int   m_run [3];

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_rd[i]   = 1'b0;
        m_addr[i] = 1'b0;
        m_run[i]  = 0;
      end else begin
        if (m_rd[i] && !(rd[i] && addr[i] == m_addr[i]))
          check($sformatf("read_width_inst%0d_addr%0d", i, m_addr[i]), m_run[i], lat_of(i) + 1);
        if (rd[i]) m_run[i] = (m_rd[i] && addr[i] == m_addr[i]) ? m_run[i] + 1 : 1;
        else       m_run[i] = 0;
        m_rd[i]   = rd[i];
        m_addr[i] = addr[i];
        if (done[i]) begin
          if (i == 0) begin
            done_cnt0++;
            if (sb.size() == 0) begin
              check("unexpected_done", 32'd1, 32'd0);
            end else begin
              exp_t e;
              e = sb.pop_front();
              check("id_ok",    idok[0], e.id_ok);
              check("ts_ok",    tsok[0], e.ts_ok);
              check("id_value", idv[0],  e.id_v);
              check("ts_value", tsv[0],  e.ts_v);
              check("attempts", att[0],  e.att);
              check("latency",  cyc - acc[0], e.lat);
            end
          end else begin
            check($sformatf("latency_inst%0d", i), cyc - acc[i], 2 * lat_of(i) + 4);
            check($sformatf("result_inst%0d", i), {idok[i], tsok[i], att[i]}, {2'b11, 4'd1});
            check($sformatf("values_inst%0d", i), idv[i] ^ tsv[i], id_word[i] ^ ts_word[i]);
          end
        end
      end
    end
  end

  task automatic push_exp();
    exp_t e;
    int   passes;
    e.id_ok = (id_word[0] == EXP_ID);
    e.ts_ok = (ts_word[0] == EXP_TS);
    e.id_v  = id_word[0];
    e.ts_v  = ts_word[0];
`ifdef SYSID_VERIFIER_RETRY_EN
    passes = (e.id_ok && e.ts_ok) ? 1 : RETRIES + 1;
`else
    passes = 1;
`endif
    e.att = 4'(passes);
    e.lat = passes * (2 * 1 + 3) + 1;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clock); #2 start = 1'b1;
    push_exp();
    @(posedge clock); #2 start = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {28'd0, busy[0], done[0], rd[0], addr[0]}, 32'd0);
    check({tag, "_id_value"}, idv[0], 32'd0);
    check({tag, "_ts_value"}, tsv[0], 32'd0);
    check({tag, "_flags"}, {26'd0, idok[0], tsok[0], att[0]}, 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      id_word[i] = EXP_ID;
      ts_word[i] = EXP_TS;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    @(posedge clock); #2 reset = 1'b0;

    // Matching words: single pass, latency 6
    pulse_start();
    wait_drain("match", 100);
    repeat (3) @(negedge clock);
    check("hold_ts_value", tsv[0], EXP_TS);
    check("hold_flags", {idok[0], tsok[0], att[0]}, {2'b11, 4'd1});

    // Timestamp off by one
    ts_word[0] = 32'h534D_4BA4;
    pulse_start();
    wait_drain("ts_mismatch", 200);
    ts_word[0] = EXP_TS;

    // ID mismatch
    id_word[0] = 32'h0000_0001;
    pulse_start();
    wait_drain("id_mismatch", 200);
    id_word[0] = EXP_ID;

    // Start pulsed while busy must be ignored
    pulse_start();
    @(posedge clock); #2 start = 1'b1;
    @(posedge clock); #2 start = 1'b0;
    wait_drain("busy_start", 100);
    repeat (10) @(negedge clock);

    // Start held high: three back-to-back passes with a single idle cycle between them
    push_exp(); push_exp(); push_exp();
    @(posedge clock); #2 start = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n = 0;
      while (busy[0] && n < 50) begin
        @(negedge clock);
        n++;
      end
      check($sformatf("gap%0d_seen", k), busy[0], 1'b0);
      @(negedge clock);
      check($sformatf("gap%0d_one_cycle", k), busy[0], 1'b1);
    end
    start = 1'b0;
    wait_drain("held_start", 100);
    repeat (40) @(negedge clock);

    // Reset in RD_TS aborts the pass with no done pulse
    pulse_start();
    @(posedge clock);
    @(posedge clock); #2;
    check("in_rd_ts", {rd[0], addr[0]}, 2'b11);
    reset = 1'b1;
    #1;
    check_zero("abort");
    sb.delete();
    d0 = done_cnt0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    repeat (20) @(negedge clock);
    check("no_done_after_abort", done_cnt0, d0);

    // Clean pass after the abort
    pulse_start();
    wait_drain("post_reset", 100);
    repeat (30) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sysid_verifier.md
SYSID_VERIFIER -- requirements
Module: sysid_verifier

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000: expected word at sysid address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h534D_4BA5: expected word at sysid address 1.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal range 0..7: cycles from address presented to readdata valid.
REQ-004 SHALL have parameter RETRY_MAX, default 3, legal range 0..15: extra read passes on mismatch (used only when SYSID_VERIFIER_RETRY_EN is defined).
REQ-005 SHALL have port clock, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: request a verification pass.
REQ-008 SHALL have port sysid_address, output, 1: address to the sysid control slave.
REQ-009 SHALL have port sysid_read, output, 1: high while a sysid read is in progress.
REQ-010 SHALL have port sysid_readdata, input, 32: readdata from the sysid control slave.
REQ-011 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have ports id_ok and ts_ok, outputs, 1 each: compare results.
REQ-014 SHALL have ports id_value and ts_value, outputs, 32 each: captured words.
REQ-015 SHALL have port attempts, output, 4: number of passes executed in the last run.

Function
REQ-016 SHALL implement FSM states IDLE, RD_ID, RD_TS, CHECK, DONE.
REQ-017 IDLE: start high accepted -> RD_ID next cycle; id_ok, ts_ok cleared, attempts set to 1 on acceptance.
REQ-018 RD_ID: sysid_address=0, sysid_read=1 for exactly READ_LATENCY+1 cycles; sysid_readdata captured into id_value on the last cycle; -> RD_TS.
REQ-019 RD_TS: sysid_address=1, sysid_read=1 for exactly READ_LATENCY+1 cycles; capture into ts_value on the last cycle; -> CHECK.
REQ-020 CHECK: one cycle; registers id_ok=(id_value==EXPECTED_ID), ts_ok=(ts_value==EXPECTED_TS); -> DONE (or retry per REQ-029).
REQ-021 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-022 Single-pass latency SHALL be exactly 2*(READ_LATENCY+1)+2 cycles from the start-sampling edge to the edge on which done is registered high (6 cycles at READ_LATENCY=1).
REQ-023 busy SHALL be high in RD_ID, RD_TS, CHECK, DONE; low in IDLE.
REQ-024 start while busy SHALL be ignored; start held high continuously SHALL begin a new pass on the cycle after DONE.
REQ-025 Outside RD_ID/RD_TS, sysid_read=0 and sysid_address=0.
REQ-026 id_value, ts_value, id_ok, ts_ok, attempts SHALL hold their values from DONE until the next start acceptance.
REQ-027 The latency counter SHALL be 3 bits, reload at each read-state entry, never wrap within a state.

Reset
REQ-028 On reset: state IDLE; sysid_address, sysid_read, busy, done, id_ok, ts_ok = 0; id_value, ts_value = 0; attempts = 0. Reset mid-pass SHALL abort immediately with no done pulse.

Configuration
REQ-029 With SYSID_VERIFIER_RETRY_EN defined: in CHECK, if !(id_ok&&ts_ok) and attempts<=RETRY_MAX, go to RD_ID, increment attempts, and suppress done; otherwise -> DONE.
REQ-030 Without SYSID_VERIFIER_RETRY_EN: no retry logic; CHECK always -> DONE; attempts reads 1 after any completed pass.

Verification
REQ-031 Defaults, slave returns 0 / 32'h534D4BA5, pulse start -> done 6 cycles later, id_ok=1, ts_ok=1, attempts=1.
REQ-032 Slave returns 32'h534D4BA4 at address 1 -> id_ok=1, ts_ok=0, ts_value=32'h534D4BA4; with RETRY_EN, attempts=4 and done after 4 passes.
REQ-033 READ_LATENCY=0 and 7 -> sysid_read width per address 1 and 8 cycles; done at 4 and 18 cycles.
REQ-034 Reset asserted in RD_TS -> all outputs zero same cycle, no done, next start runs a clean pass.
REQ-035 start pulsed during busy -> ignored; start held high -> back-to-back passes, busy low exactly one cycle between them.
